key_event_encoder: RTL

//  Consumes the per-button press pulses and hold indicators from the edge/hold detectors.

---
 rtl/key_event_pkg.sv | 41 ++++
 rtl/key_event_fifo.sv | 72 +++++++
 rtl/key_event_encoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// -----------------------------------------------------------------------------
// key_event_pkg
// Shared definitions for the key event encoder:
//   - default key count and event FIFO depth
//   - event word layout: the long-press flag is the MSB, the key index sits
//     in bits [KEY_W-1:0]
//   - saturating 8-bit add used by the optional drop counter
//     (the counter only exists when KEY_EVT_DROP_CNT_EN is defined)
// -----------------------------------------------------------------------------
package key_event_pkg;

  localparam int DEF_N_KEYS       = 20;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_KEY_W        = $clog2(DEF_N_KEYS);
  localparam int DEF_EVT_W        = DEF_KEY_W + 1;
  localparam int DEF_EVT_LONG_BIT = DEF_EVT_W - 1;

  localparam int          DROP_CNT_W   = 8;
  localparam int unsigned DROP_CNT_MAX = 255;

  // Event word width for a given key index width: one extra bit for "long".
  function automatic int evt_width(input int key_w);
    return key_w + 1;
  endfunction

  // Position of the long-press flag inside the event word (always the MSB).
  function automatic int evt_long_bit(input int key_w);
    return key_w;
  endfunction

  // base + inc, clamped to 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] base, input int unsigned inc);
    int unsigned sum;
    sum = {24'd0, base} + inc;
    if (sum > DROP_CNT_MAX) begin
      return 8'hFF;
    end
    return sum[7:0];
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// -----------------------------------------------------------------------------
// key_event_fifo
// Synchronous FIFO, parameterised width and depth (depth a power of 2, >=2).
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.  Push and pop in the same cycle are
// accepted at any occupancy, including full (the head slot is read out before
// it is overwritten).
// Ports:
//   clk, resetn   clock, asynchronous active-low reset (pointers only)
//   push, din     write request and data; ignored when full without a pop
//   pop           read request; ignored when empty
//   dout          head entry (combinational from storage)
//   full, empty   occupancy flags
// -----------------------------------------------------------------------------
module key_event_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// -----------------------------------------------------------------------------
// key_event_encoder
// Turns per-key press pulses (with a hold indicator sampled alongside) into a
// serial stream of {long, key_index} events delivered over valid/ready.
// Each key has a one-deep pending slot, so simultaneous presses are kept and
// drained lowest index first, one per cycle, into a small event FIFO.
// A re-press of a key whose previous press is still pending is dropped and
// flagged on the sticky overflow output.
//
// Optional feature macro: KEY_EVT_DROP_CNT_EN
//   defined   -> extra output drop_cnt[7:0], saturating count of dropped
//                presses, cleared by clr_overflow (a drop in the same cycle
//                still counts)
//   undefined -> no drop_cnt port and no counter
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   press[N]       one-cycle press pulses
//   hold[N]        hold indicators, sampled with the press
//   evt_valid      FIFO head holds an event
//   evt_ready      consumer takes the head event
//   evt_key        key index of the head event (0 when empty)
//   evt_long       long-press flag of the head event (0 when empty)
//   clr_overflow   synchronous clear of overflow (and drop_cnt)
//   overflow       sticky drop indicator
//   drop_cnt       dropped press count (KEY_EVT_DROP_CNT_EN only)
// -----------------------------------------------------------------------------
module key_event_encoder
  import key_event_pkg::*;
#(
  parameter  int N_KEYS     = DEF_N_KEYS,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int KEY_W      = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] press,
  input  logic [N_KEYS-1:0] hold,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KEY_W-1:0]  evt_key,
  output logic              evt_long,
  input  logic              clr_overflow,
  output logic              overflow
`ifdef KEY_EVT_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int EVT_W        = evt_width(KEY_W);
  localparam int EVT_LONG_BIT = evt_long_bit(KEY_W);

  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] long_pend_q, long_pend_d;
  logic              overflow_q, overflow_d;

  logic              disp_found;
  logic [KEY_W-1:0]  disp_key;
  logic [N_KEYS-1:0] disp_vec;
  logic [N_KEYS-1:0] drop_vec;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EVT_W-1:0]  fifo_din;
  logic [EVT_W-1:0]  fifo_dout;

  // Lowest-index pending key; scanning downwards lets the lowest hit win.
  always_comb begin
    disp_found = 1'b0;
    disp_key   = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        disp_found = 1'b1;
        disp_key   = KEY_W'(i);
      end
    end
  end

  // A slot frees up in the FIFO this cycle if it is not full or the head is
  // being consumed, so dispatch can proceed even at full occupancy.
  always_comb begin
    fifo_pop  = ~fifo_empty & evt_ready;
    fifo_push = disp_found & (~fifo_full | fifo_pop);
    disp_vec  = fifo_push ? (N_KEYS'(1) << disp_key) : '0;
    fifo_din  = '0;
    fifo_din[EVT_LONG_BIT] = long_pend_q[disp_key];
    fifo_din[KEY_W-1:0]    = disp_key;
  end

  // A press on a key that is pending and not leaving this cycle is a drop.
  // A press on the key being dispatched re-arms the slot with the new hold.
  always_comb begin
    drop_vec    = press & pending_q & ~disp_vec;
    pending_d   = (pending_q & ~disp_vec) | press;
    long_pend_d = long_pend_q;
    for (int i = 0; i < N_KEYS; i++) begin
      if (press[i] && !drop_vec[i]) begin
        long_pend_d[i] = hold[i];
      end
    end
    overflow_d = overflow_q;
    if (|drop_vec) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q   <= '0;
      long_pend_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      long_pend_q <= long_pend_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef KEY_EVT_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Clear first, then add this cycle's drops, so a simultaneous drop survives.
  always_comb begin
    drop_cnt_d = sat_add8(clr_overflow ? 8'd0 : drop_cnt_q,
                          int'($countones(drop_vec)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  key_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (fifo_din),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign evt_valid = ~fifo_empty;
  assign evt_key   = fifo_empty ? '0 : fifo_dout[KEY_W-1:0];
  assign evt_long  = ~fifo_empty & fifo_dout[EVT_LONG_BIT];
  assign overflow  = overflow_q;

endmodule
